mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Memory-stage controller that consumes the execute stage's result: ALU result as effective address, second register operand as store data.
- Sequences one load or store per instruction against a multi-cycle, stalling data memory using a request/done handshake.
- Stalls the pipeline while an access is in flight and returns load data to writeback.
- Flags unaligned, illegal and timed-out accesses as a sticky error that halts the core.

Parameters:
- ADDR_W, 16, address width (effective address from execute)
- DATA_W, 16, data width
- TIMEOUT, 31, max cycles in WAIT before error; counter width = clog2(TIMEOUT+1)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  instruction in memory stage is valid
- mem_read  in  1  instruction is a load
- mem_write  in  1  instruction is a store
- alu_res  in  ADDR_W  effective address from execute
- store_data  in  DATA_W  store operand (read2data forwarded)
- stall_pipe  out  1  hold all earlier pipeline stages
- load_data  out  DATA_W  captured load result
- load_valid  out  1  load_data valid this cycle (one-cycle pulse)
- err  out  1  sticky access error
- dm_en  out  1  memory request strobe
- dm_wr  out  1  request is a write (qualified by dm_en)
- dm_addr  out  ADDR_W  request address
- dm_wdata  out  DATA_W  request write data
- dm_stall  in  1  memory busy; request not accepted this cycle
- dm_done  in  1  access complete; dm_rdata valid for reads
- dm_rdata  in  DATA_W  read data

Behaviour:
- Reset values: state=IDLE; stall_pipe=0, load_valid=0, err=0, dm_en=0, dm_wr=0; load_data, dm_addr, dm_wdata and timeout count all 0. Reset overrides any state, including mid-access. dm_en is low the cycle after rst. Any late dm_done is ignored.
- mem_op = req_valid & (mem_read | mem_write).
- stall_pipe (combinational) = (IDLE & mem_op) | REQ | WAIT | ERR. It is low in DONE, so the pipe advances exactly once per access.
- IDLE:
  - If mem_op & mem_read & mem_write → ERR (illegal).
  - Else if mem_op & alu_res[0] → ERR (unaligned word access).
  - Else if mem_op → latch addr, wdata and op into dm_* registers, then go to REQ.
  - Else stay.
- REQ:
  - dm_en=1 with latched dm_wr/addr/wdata. Outputs are registered and held stable while in REQ.
  - If dm_stall → stay in REQ and re-present the identical request next cycle.
  - Else if dm_done in the same cycle → DONE.
  - Else → WAIT.
- WAIT:
  - dm_en=0; count increments each cycle.
  - If dm_done → DONE.
  - Else if count==TIMEOUT → ERR.
- DONE (one cycle):
  - Load: load_data <= dm_rdata captured on the dm_done edge; load_valid=1 in DONE only.
  - Store: load_valid=0.
  - Clear count; next state IDLE unconditionally. mem_op in the DONE cycle belongs to the previous instruction and is ignored.
- ERR: err=1 and stall_pipe=1 permanently; dm_en=0; exit only by rst.
- load_data holds its last value until the next load completes. No data width conversion; full-word only.
- Back-to-back memory ops: IDLE→REQ→…→DONE→IDLE. Minimum 3 cycles per access (IDLE detect, REQ, DONE) when dm_done coincides with acceptance.
- Non-memory instructions pass with zero stall in IDLE.

Decomposition:
- Shared package mem_ctrl_pkg holds:
  - state encoding typedef (IDLE, REQ, WAIT, DONE, ERR)
  - DATA_W/ADDR_W defaults
  - TIMEOUT default
- One natural sub-module: mem_timeout_ctr, a clearable, saturating up-counter with a terminal-count flag, also reused by the instruction-fetch side.
- The FSM and datapath registers stay in the top module.

Test Plan:
- Load, zero wait: alu_res=0x0010, mem_read=1; memory returns dm_done with rdata=0xBEEF in the REQ cycle → dm_en high exactly 1 cycle at addr 0x0010; load_valid pulses in DONE with load_data=0xBEEF; stall_pipe high for 2 cycles.
- Store with backpressure: alu_res=0x0020, store_data=0x1234, mem_write=1, dm_stall=1 for 3 cycles → dm_en held 4 cycles with stable addr/data/dm_wr=1; done 2 cycles later → DONE, load_valid=0, return to IDLE.
- Unaligned: alu_res=0x0011, mem_read=1 → next cycle err=1, stall_pipe=1, dm_en never asserted; persists until rst.
- Timeout: accepted read, dm_done never arrives → err rises after exactly TIMEOUT WAIT cycles (31); with TIMEOUT overridden to 4, after 4 cycles.
- Reset mid-access: rst asserted in WAIT → next cycle IDLE, all outputs at reset values; a dm_done arriving after reset produces no load_valid.
- Back-to-back: load 0x0002 then store 0x0004 on consecutive instructions → two distinct requests in order, no duplicated request, and the DONE cycle does not re-trigger the first op.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the memory-stage access controller.
// Also consumed by the fetch-side timeout logic.
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Clearable saturating up-counter with a terminal-count flag.
// Shared by the data-memory and instruction-fetch controllers.
module mem_timeout_ctr #(
  parameter int MAX = 31,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == W'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !tc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: one load/store per instruction against a
// stalling data memory, with sticky error on bad or timed-out access.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] alu_res,
  input  logic [DATA_W-1:0] store_data,
  output logic              stall_pipe,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              err,
  output logic              dm_en,
  output logic              dm_wr,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_stall,
  input  logic              dm_done,
  input  logic [DATA_W-1:0] dm_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic              dm_wr_q, dm_wr_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d;
  logic [DATA_W-1:0] load_data_q, load_data_d;
  logic              mem_op;
  logic              cnt_clr, cnt_inc, cnt_tc;

  assign mem_op = req_valid & (mem_read | mem_write);

  // Count is 1 on the first WAIT cycle, so tc marks the last allowed one.
  mem_timeout_ctr #(
    .MAX (TIMEOUT),
    .W   (CNT_W)
  ) u_tmo (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .tc  (cnt_tc)
  );

  always_comb begin
    state_d     = state_q;
    dm_wr_d     = dm_wr_q;
    dm_addr_d   = dm_addr_q;
    dm_wdata_d  = dm_wdata_q;
    load_data_d = load_data_q;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_clr = 1'b1;
        if (mem_op && mem_read && mem_write) begin
          state_d = S_ERR;
        end else if (mem_op && alu_res[0]) begin
          state_d = S_ERR;
        end else if (mem_op) begin
          dm_wr_d    = mem_write;
          dm_addr_d  = alu_res;
          dm_wdata_d = store_data;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (!dm_stall) begin
          if (dm_done) begin
            state_d = S_DONE;
            if (!dm_wr_q) load_data_d = dm_rdata;
          end else begin
            state_d = S_WAIT;
            cnt_inc = 1'b1;
          end
        end
      end
      S_WAIT: begin
        cnt_inc = 1'b1;
        if (dm_done) begin
          state_d = S_DONE;
          if (!dm_wr_q) load_data_d = dm_rdata;
        end else if (cnt_tc) begin
          state_d = S_ERR;
        end
      end
      S_DONE: begin
        cnt_clr = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dm_wr_q     <= 1'b0;
      dm_addr_q   <= '0;
      dm_wdata_q  <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      dm_wr_q     <= dm_wr_d;
      dm_addr_q   <= dm_addr_d;
      dm_wdata_q  <= dm_wdata_d;
      load_data_q <= load_data_d;
    end
  end

  assign dm_en      = (state_q == S_REQ);
  assign dm_wr      = dm_wr_q;
  assign dm_addr    = dm_addr_q;
  assign dm_wdata   = dm_wdata_q;
  assign load_data  = load_data_q;
  assign load_valid = (state_q == S_DONE) && !dm_wr_q;
  assign err        = (state_q == S_ERR);
  assign stall_pipe = ((state_q == S_IDLE) && mem_op)
                    || (state_q == S_REQ)
                    || (state_q == S_WAIT)
                    || (state_q == S_ERR);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table, request and
// load-data scoreboards, and hand sequences for error/reset corners.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, mem_read, mem_write;
  logic [15:0] alu_res, store_data;
  logic        dm_stall, dm_done;
  logic [15:0] dm_rdata;

  logic        stall_pipe, load_valid, err, dm_en, dm_wr;
  logic [15:0] load_data, dm_addr, dm_wdata;

  logic        stall_pipe4, load_valid4, err4, dm_en4, dm_wr4;
  logic [15:0] load_data4, dm_addr4, dm_wdata4;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(31)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .mem_read(mem_read), .mem_write(mem_write),
    .alu_res(alu_res), .store_data(store_data),
    .stall_pipe(stall_pipe), .load_data(load_data),
    .load_valid(load_valid), .err(err),
    .dm_en(dm_en), .dm_wr(dm_wr), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_stall(dm_stall),
    .dm_done(dm_done), .dm_rdata(dm_rdata)
  );

  mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .mem_read(mem_read), .mem_write(mem_write),
    .alu_res(alu_res), .store_data(store_data),
    .stall_pipe(stall_pipe4), .load_data(load_data4),
    .load_valid(load_valid4), .err(err4),
    .dm_en(dm_en4), .dm_wr(dm_wr4), .dm_addr(dm_addr4),
    .dm_wdata(dm_wdata4), .dm_stall(dm_stall),
    .dm_done(dm_done), .dm_rdata(dm_rdata)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          nstall;
    int          nwait;
  } vec_t;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  req_t        exp_req[$];
  logic [15:0] exp_ld[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_load = 16'h0000;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request scoreboard: every presented request must match the head;
  // it is consumed on the cycle memory accepts it.
  always @(negedge clk) begin
    req_t e;
    if (!rst && dm_en) begin
      if (exp_req.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req actual=%0h expected=none", dm_addr);
      end else begin
        e = exp_req[0];
        check("req_wr", {31'd0, dm_wr}, {31'd0, e.wr});
        check("req_addr", {16'd0, dm_addr}, {16'd0, e.addr});
        check("req_wdata", {16'd0, dm_wdata}, {16'd0, e.wdata});
        if (!dm_stall) void'(exp_req.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] d;
    if (!rst && load_valid) begin
      if (exp_ld.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_load_valid actual=%0h expected=none", load_data);
      end else begin
        d = exp_ld.pop_front();
        check("load_data", {16'd0, load_data}, {16'd0, d});
      end
    end
  end

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_res    = '0;
    store_data = '0;
    dm_stall   = 1'b0;
    dm_done    = 1'b0;
    dm_rdata   = 16'hDEAD;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    last_load = 16'h0000;
  endtask

  task automatic run_op(input vec_t v);
    int st;
    int en;
    st = 0;
    en = 0;
    req_valid  = 1'b1;
    mem_read   = v.rd;
    mem_write  = v.wr;
    alu_res    = v.addr;
    store_data = v.wdata;
    dm_stall   = 1'b0;
    dm_done    = 1'b0;
    dm_rdata   = ~v.rdata;
    if (!(v.rd || v.wr)) begin
      @(negedge clk);
      check("nonmem_stall", {31'd0, stall_pipe}, 32'd0);
      step();
      @(negedge clk);
      check("nonmem_en", {31'd0, dm_en}, 32'd0);
      req_valid = 1'b0;
      step();
      return;
    end
    exp_req.push_back('{wr: v.wr, addr: v.addr, wdata: v.wdata});
    if (v.rd) exp_ld.push_back(v.rdata);
    @(negedge clk);
    if (stall_pipe) st++;
    if (dm_en) en++;
    step();
    for (int i = 0; i < v.nstall; i++) begin
      dm_stall = 1'b1;
      @(negedge clk);
      if (stall_pipe) st++;
      if (dm_en) en++;
      step();
    end
    dm_stall = 1'b0;
    if (v.nwait == 0) begin
      dm_done  = 1'b1;
      dm_rdata = v.rdata;
    end
    @(negedge clk);
    if (stall_pipe) st++;
    if (dm_en) en++;
    step();
    dm_done  = 1'b0;
    dm_rdata = ~v.rdata;
    for (int i = 1; i <= v.nwait; i++) begin
      if (i == v.nwait) begin
        dm_done  = 1'b1;
        dm_rdata = v.rdata;
      end
      @(negedge clk);
      if (stall_pipe) st++;
      if (dm_en) en++;
      step();
      dm_done  = 1'b0;
      dm_rdata = ~v.rdata;
    end
    @(negedge clk);
    check("done_load_valid", {31'd0, load_valid}, {31'd0, v.rd});
    check("done_stall", {31'd0, stall_pipe}, 32'd0);
    check("done_en", {31'd0, dm_en}, 32'd0);
    check("stall_cycles", st, 2 + v.nstall + v.nwait);
    check("en_cycles", en, 1 + v.nstall);
    if (v.wr) begin
      check("store_keeps_load", {16'd0, load_data}, {16'd0, last_load});
    end else begin
      last_load = v.rdata;
    end
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int   w4;
    int   w31;
    vecs[0] = '{rd: 1, wr: 0, addr: 16'h0010, wdata: 16'h0000,
                rdata: 16'hBEEF, nstall: 0, nwait: 0};
    vecs[1] = '{rd: 0, wr: 1, addr: 16'h0020, wdata: 16'h1234,
                rdata: 16'h0000, nstall: 3, nwait: 2};
    vecs[2] = '{rd: 1, wr: 0, addr: 16'h0002, wdata: 16'hAAAA,
                rdata: 16'h5A5A, nstall: 0, nwait: 1};
    vecs[3] = '{rd: 0, wr: 1, addr: 16'h0004, wdata: 16'h00FF,
                rdata: 16'h0000, nstall: 0, nwait: 0};
    vecs[4] = '{rd: 1, wr: 0, addr: 16'hFFFE, wdata: 16'h0F0F,
                rdata: 16'h8001, nstall: 1, nwait: 3};
    vecs[5] = '{rd: 0, wr: 0, addr: 16'h0013, wdata: 16'h0000,
                rdata: 16'h0000, nstall: 0, nwait: 0};

    do_reset();
    @(negedge clk);
    check("rst_stall", {31'd0, stall_pipe}, 32'd0);
    check("rst_load_valid", {31'd0, load_valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_dm_en", {31'd0, dm_en}, 32'd0);
    check("rst_dm_wr", {31'd0, dm_wr}, 32'd0);
    check("rst_load_data", {16'd0, load_data}, 32'd0);
    check("rst_dm_addr", {16'd0, dm_addr}, 32'd0);
    check("rst_dm_wdata", {16'd0, dm_wdata}, 32'd0);
    step();

    foreach (vecs[i]) run_op(vecs[i]);

    // Unaligned load: straight to error, no request ever issued
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    alu_res = 16'h0011;
    @(negedge clk);
    check("ua_stall_idle", {31'd0, stall_pipe}, 32'd1);
    step();
    req_valid = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    check("ua_err", {31'd0, err}, 32'd1);
    check("ua_stall", {31'd0, stall_pipe}, 32'd1);
    check("ua_en", {31'd0, dm_en}, 32'd0);
    repeat (5) @(negedge clk);
    check("ua_sticky", {31'd0, err}, 32'd1);
    do_reset();
    @(negedge clk);
    check("ua_rst_err", {31'd0, err}, 32'd0);
    check("ua_rst_stall", {31'd0, stall_pipe}, 32'd0);
    step();

    // Illegal: load and store together
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b1;
    alu_res = 16'h0008;
    step();
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    check("ill_err", {31'd0, err}, 32'd1);
    check("ill_en", {31'd0, dm_en}, 32'd0);
    do_reset();

    // Timeout: accepted read that never completes
    exp_req.push_back('{wr: 1'b0, addr: 16'h0030, wdata: 16'h1111});
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    alu_res = 16'h0030; store_data = 16'h1111;
    step();
    @(negedge clk);
    check("tmo_req_en", {31'd0, dm_en}, 32'd1);
    check("tmo_req_en4", {31'd0, dm_en4}, 32'd1);
    w4  = -1;
    w31 = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      @(negedge clk);
      if (err4 && w4 < 0) w4 = i - 1;
      if (err && w31 < 0) w31 = i - 1;
    end
    check("tmo_wait4", w4, 4);
    check("tmo_wait31", w31, 31);
    check("tmo_stall", {31'd0, stall_pipe}, 32'd1);
    check("tmo_en", {31'd0, dm_en}, 32'd0);
    do_reset();

    // Reset while waiting, then a late dm_done
    exp_req.push_back('{wr: 1'b0, addr: 16'h0040, wdata: 16'h2222});
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    alu_res = 16'h0040; store_data = 16'h2222;
    step();
    step();
    @(negedge clk);
    check("mid_wait_stall", {31'd0, stall_pipe}, 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; req_valid = 1'b0; mem_read = 1'b0;
    dm_done = 1'b1; dm_rdata = 16'h7777;
    @(negedge clk);
    check("mid_stall", {31'd0, stall_pipe}, 32'd0);
    check("mid_en", {31'd0, dm_en}, 32'd0);
    check("mid_err", {31'd0, err}, 32'd0);
    check("mid_load_data", {16'd0, load_data}, 32'd0);
    check("mid_dm_addr", {16'd0, dm_addr}, 32'd0);
    step();
    dm_done = 1'b0;
    @(negedge clk);
    check("mid_late_done", {31'd0, load_valid}, 32'd0);
    step();

    check("req_queue_empty", exp_req.size(), 0);
    check("ld_queue_empty", exp_ld.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
